tmds_rx_decoder: RTL and testbench

TMDS_RX_DECODER -- requirements
Module: tmds_rx_decoder

---
 rtl/tmds_rx_decoder.sv | 138 +++++++++++++
 tb/tb_tmds_rx_decoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/tmds_rx_decoder.sv
// tmds_rx_decoder: TMDS word aligner and symbol decoder with pixel position tracking
// Ports:
//   clk, reset              pixel clock, asynchronous active-high reset
//   tmds_in[9:0]            raw deserialized word, bit 0 received first
//   locked, bit_offset[3:0] alignment status and current slip offset
//   de, data[7:0], ctrl[1:0] decoded symbol (registered, zero while searching)
//   hsync, vsync            ctrl[0], ctrl[1]
//   pix_x, pix_y[10:0]      position of the current data word
//   frame_start             one-cycle pulse on vsync rise
module tmds_rx_decoder #(
  parameter int LOCK_RUN      = 16,
  parameter int SEARCH_WINDOW = 2048,
  parameter int LOSS_LIMIT    = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  tmds_in,
  output logic        locked,
  output logic [3:0]  bit_offset,
  output logic        de,
  output logic [7:0]  data,
  output logic [1:0]  ctrl,
  output logic        hsync,
  output logic        vsync,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        frame_start
);
  localparam int RW = $clog2(LOCK_RUN + 1);
  localparam int WW = $clog2(SEARCH_WINDOW + 1);
  localparam int LW = $clog2(LOSS_LIMIT + 1);
  typedef enum logic {SEARCH, LOCKED} state_t;
  state_t        r_state, w_state_nx;
  logic [9:0]    r_prev, r_aligned;
  logic [3:0]    r_offset, w_offset_nx;
  logic [RW-1:0] r_run, w_run_nx;
  logic [WW-1:0] r_win, w_win_nx;
  logic [LW-1:0] r_loss, w_loss_nx;
  logic          r_de, r_fs;
  logic [7:0]    r_data;
  logic [1:0]    r_ctrl;
  logic [10:0]   r_x, r_y;
  logic [19:0]   w_window;
  logic          w_is_ctrl, w_live, w_de_nx, w_vs_rise, w_line_end;
  logic [1:0]    w_ctrl_dec, w_ctrl_nx;
  logic [7:0]    w_q, w_data_dec, w_data_nx;
  logic [10:0]   w_x_inc, w_y_inc, w_x_nx, w_y_nx;
  assign w_window   = {tmds_in, r_prev};
  assign w_is_ctrl  = (r_aligned == 10'h354) || (r_aligned == 10'h0AB) ||
                      (r_aligned == 10'h154) || (r_aligned == 10'h2AB);
  assign w_ctrl_dec = (r_aligned == 10'h0AB) ? 2'b01 :
                      (r_aligned == 10'h154) ? 2'b10 :
                      (r_aligned == 10'h2AB) ? 2'b11 : 2'b00;
  assign w_q        = r_aligned[9] ? ~r_aligned[7:0] : r_aligned[7:0];
  // bit 8 selects XOR (1) or XNOR (0) chaining of the transition-minimised byte
  assign w_data_dec = {w_q[7:1] ^ w_q[6:0] ^ {7{~r_aligned[8]}}, w_q[0]};
  always_comb begin
    w_state_nx  = r_state;
    w_offset_nx = r_offset;
    w_run_nx    = r_run;
    w_win_nx    = r_win;
    w_loss_nx   = r_loss;
    if (r_state == SEARCH) begin
      w_run_nx = w_is_ctrl ? r_run + 1'b1 : '0;
      w_win_nx = r_win + 1'b1;
      if (w_is_ctrl && r_run == RW'(LOCK_RUN - 1)) begin
        w_state_nx = LOCKED;
        w_run_nx   = '0;
        w_win_nx   = '0;
        w_loss_nx  = '0;
      end else if (r_win == WW'(SEARCH_WINDOW - 1)) begin
        w_offset_nx = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
        w_run_nx    = '0;
        w_win_nx    = '0;
      end
    end else begin
      w_loss_nx = w_is_ctrl ? '0 : r_loss + 1'b1;
      if (!w_is_ctrl && r_loss == LW'(LOSS_LIMIT - 1)) begin
        w_state_nx = SEARCH;
        w_loss_nx  = '0;
        w_run_nx   = '0;
        w_win_nx   = '0;
      end
    end
  end
  // outputs are gated by the next state so they change on the same edge as locked
  assign w_live     = (w_state_nx == LOCKED);
  assign w_de_nx    = w_live && !w_is_ctrl;
  assign w_data_nx  = w_de_nx ? w_data_dec : 8'h00;
  assign w_ctrl_nx  = (w_live && w_is_ctrl) ? w_ctrl_dec : 2'b00;
  assign w_vs_rise  = w_ctrl_nx[1] && !r_ctrl[1];
  assign w_line_end = r_de && !w_de_nx;
  assign w_x_inc    = (r_x == 11'd2047) ? r_x : r_x + 11'd1;
  assign w_y_inc    = (r_y == 11'd2047) ? r_y : r_y + 11'd1;
  assign w_x_nx     = (!w_live || w_line_end) ? 11'd0 : r_de ? w_x_inc : r_x;
  assign w_y_nx     = (!w_live || w_vs_rise) ? 11'd0 : w_line_end ? w_y_inc : r_y;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= SEARCH;
      r_prev    <= '0;
      r_aligned <= '0;
      r_offset  <= '0;
      r_run     <= '0;
      r_win     <= '0;
      r_loss    <= '0;
      r_de      <= 1'b0;
      r_data    <= '0;
      r_ctrl    <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_fs      <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_prev    <= tmds_in;
      r_aligned <= w_window[r_offset +: 10];
      r_offset  <= w_offset_nx;
      r_run     <= w_run_nx;
      r_win     <= w_win_nx;
      r_loss    <= w_loss_nx;
      r_de      <= w_de_nx;
      r_data    <= w_data_nx;
      r_ctrl    <= w_ctrl_nx;
      r_x       <= w_x_nx;
      r_y       <= w_y_nx;
      r_fs      <= w_vs_rise;
    end
  end
  assign locked      = (r_state == LOCKED);
  assign bit_offset  = r_offset;
  assign de          = r_de;
  assign data        = r_data;
  assign ctrl        = r_ctrl;
  assign hsync       = r_ctrl[0];
  assign vsync       = r_ctrl[1];
  assign pix_x       = r_x;
  assign pix_y       = r_y;
  assign frame_start = r_fs;
endmodule

// File: tb/tb_tmds_rx_decoder.sv
// tb_tmds_rx_decoder: directed scoreboard bench for tmds_rx_decoder
module tb_tmds_rx_decoder;
  localparam int LOCK_RUN = 16;
  localparam int SW       = 2048;
  logic        clk, reset;
  logic [9:0]  tmds_in;
  logic        locked, de, hsync, vsync, frame_start;
  logic [3:0]  bit_offset;
  logic [7:0]  data;
  logic [1:0]  ctrl;
  logic [10:0] pix_x, pix_y;
  int n_checks = 0;
  int n_err = 0;
  typedef struct {
    bit         chk;
    logic [10:0] exp;
    int         px;
    int         py;
    int         fs;
  } rec_t;
  rec_t q[$];
  tmds_rx_decoder dut (
    .clk(clk), .reset(reset), .tmds_in(tmds_in), .locked(locked),
    .bit_offset(bit_offset), .de(de), .data(data), .ctrl(ctrl),
    .hsync(hsync), .vsync(vsync), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic bit is_tok(input logic [9:0] w);
    return w == 10'h354 || w == 10'h0AB || w == 10'h154 || w == 10'h2AB;
  endfunction
  // expected {de, data, ctrl} for one aligned symbol
  function automatic logic [10:0] model(input logic [9:0] w);
    logic [7:0] qq, d;
    case (w)
      10'h354: return {1'b0, 8'h00, 2'b00};
      10'h0AB: return {1'b0, 8'h00, 2'b01};
      10'h154: return {1'b0, 8'h00, 2'b10};
      10'h2AB: return {1'b0, 8'h00, 2'b11};
      default: begin
        qq = w[9] ? ~w[7:0] : w[7:0];
        d[0] = qq[0];
        for (int i = 1; i < 8; i++) d[i] = w[8] ? (qq[i] ^ qq[i-1]) : !(qq[i] ^ qq[i-1]);
        return {1'b1, d, 2'b00};
      end
    endcase
  endfunction
  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    do w = 10'($urandom_range(0, 1023)); while (is_tok(w));
    return w;
  endfunction
  task automatic step(input logic [9:0] w, input bit chk, input int px, input int py, input int fs);
    rec_t r;
    tmds_in = w;
    q.push_back('{chk, model(w), px, py, fs});
    @(posedge clk);
    #1;
    if (q.size() == 3) begin
      r = q.pop_front();
      if (r.chk) begin
        check("de", de, r.exp[10]);
        check("data", data, r.exp[9:2]);
        check("ctrl", ctrl, r.exp[1:0]);
        check("hsync", hsync, r.exp[0]);
        check("vsync", vsync, r.exp[1]);
        if (r.px >= 0) check("pix_x", pix_x, r.px);
        if (r.py >= 0) check("pix_y", pix_y, r.py);
        if (r.fs >= 0) check("frame_start", frame_start, r.fs);
      end
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_offset"}, bit_offset, 0);
    check({tag, "_de"}, de, 0);
    check({tag, "_data"}, data, 0);
    check({tag, "_ctrl"}, ctrl, 0);
    check({tag, "_hsync"}, hsync, 0);
    check({tag, "_vsync"}, vsync, 0);
    check({tag, "_pix_x"}, pix_x, 0);
    check({tag, "_pix_y"}, pix_y, 0);
    check({tag, "_fs"}, frame_start, 0);
  endtask
  initial begin
    int n;
    int t[4];
    logic [3:0] off_last;
    logic [9:0] tok, sym, ps, w;
    reset = 1'b1;
    tmds_in = '0;
    @(posedge clk);
    #1;
    check_zero("rst");
    reset = 1'b0;
    // lock on continuous 0x354 at offset 0
    n = 0;
    while (!locked && n < 40) begin
      step(10'h354, 1, -1, -1, 0);
      n++;
    end
    check("lock_cycles", n, LOCK_RUN + 2);
    check("lock_offset", bit_offset, 0);
    repeat (3) step(10'h354, 1, 0, 0, 0);
    // data decode of 0x100 and 0x2FF
    step(10'h100, 1, 0, 0, 0);
    step(10'h2FF, 1, 1, 0, 0);
    step(10'h354, 1, 0, 1, 0);
    step(10'h354, 1, 0, 1, 0);
    check("dec_2FF", data, 8'hFE);
    step(10'h354, 1, 0, 1, 0);
    // 800-word line, hsync token, then vsync rise
    for (int i = 0; i < 800; i++) step(rand_data(), 1, i, 1, 0);
    step(10'h0AB, 1, 0, 2, 0);
    step(10'h2AB, 1, 0, 0, 1);
    step(10'h354, 1, 0, 0, 0);
    step(10'h354, 1, 0, 0, 0);
    step(10'h354, 1, 0, 0, 0);
    // loss of lock after LOSS_LIMIT data words
    for (int i = 0; i < 4096; i++) step(rand_data(), 0, -1, -1, -1);
    check("loss_still_locked", locked, 1);
    check("loss_de", de, 1);
    check("pix_x_sat", pix_x, 2047);
    step(rand_data(), 0, -1, -1, -1);
    step(rand_data(), 0, -1, -1, -1);
    check("lost_locked", locked, 0);
    check("lost_de", de, 0);
    check("lost_pix_x", pix_x, 0);
    check("lost_pix_y", pix_y, 0);
    q.delete();
    n = 0;
    while (!locked && n < 40) begin
      step(10'h354, 1, -1, -1, 0);
      n++;
    end
    check("relock_cycles", n, LOCK_RUN + 2);
    // offset search on 0x154 delayed by 3 bits
    reset = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    tok = 10'h154;
    w = {tok[6:0], tok[9:7]};
    t = '{0, 0, 0, 0};
    off_last = 4'd0;
    n = 0;
    while (!locked && n < 7000) begin
      step(w, 0, -1, -1, -1);
      n++;
      if (bit_offset != off_last) begin
        if (bit_offset < 4) t[bit_offset] = n;
        off_last = bit_offset;
      end
    end
    check("slip1_at", t[1], SW);
    check("slip2_gap", t[2] - t[1], SW);
    check("slip3_gap", t[3] - t[2], SW);
    check("off3_lock_cycles", n, 3 * SW + 1 + LOCK_RUN);
    check("off3_offset", bit_offset, 3);
    // data at offset 3, then reset mid-line
    ps = tok;
    sym = 10'h100;
    for (int i = 0; i < 8; i++) begin
      step({sym[6:0], ps[9:7]}, 0, -1, -1, -1);
      ps = sym;
    end
    check("off3_de", de, 1);
    check("off3_data", data, 8'h00);
    check("off3_pix_x", pix_x, 5);
    #2;
    reset = 1'b1;
    #1;
    check_zero("mid");
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    repeat (40) step(w, 0, -1, -1, -1);
    check("no_relock_locked", locked, 0);
    check("no_relock_offset", bit_offset, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
